// File: rtl/cpu_pkg.sv
// Shared CPU memory-stage types: operation codes, controller states and op decode helpers.
package cpu_pkg;

    typedef enum logic [3:0] {
        NOP  = 4'd0,
        LDW  = 4'd1,
        LDH  = 4'd2,
        LDHU = 4'd3,
        LDB  = 4'd4,
        LDBU = 4'd5,
        STW  = 4'd6,
        STH  = 4'd7,
        STB  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    // Codes above STB are ALU-only operations that bypass the bus.
    function automatic logic op_is_mem(input logic [3:0] op);
        return (op >= LDW) && (op <= STB);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == STW) || (op == STH) || (op == STB);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == LDB) || (op == LDH);
    endfunction

    function automatic mem_size_e op_size(input logic [3:0] op);
        case (op)
            LDB, LDBU, STB: return SZ_BYTE;
            LDH, LDHU, STH: return SZ_HALF;
            default:        return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication and byte enables, plus load lane
// extraction with sign/zero extension (little-endian lanes).
module mem_lane_align
    import cpu_pkg::*;
#(
    parameter int WORD_DATA_WIDTH = 32,
    localparam int BE_W  = WORD_DATA_WIDTH / 8,
    localparam int OFS_W = $clog2(BE_W)
) (
    input  logic [3:0]                 op,
    input  logic [OFS_W-1:0]           ofs,
    input  logic [WORD_DATA_WIDTH-1:0] wr_data,
    input  logic [WORD_DATA_WIDTH-1:0] rd_data,
    output logic [BE_W-1:0]            be,
    output logic [WORD_DATA_WIDTH-1:0] wr_lane,
    output logic [WORD_DATA_WIDTH-1:0] rd_ext
);

    mem_size_e   size;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        ext_bit;

    assign size     = op_size(op);
    // Halfword base drops ofs[0] so the select never leaves the word.
    assign byte_sel = rd_data[{ofs, 3'b000} +: 8];
    assign half_sel = rd_data[{ofs[OFS_W-1:1], 4'b0000} +: 16];

    always_comb begin
        be      = '1;
        wr_lane = wr_data;
        rd_ext  = rd_data;
        ext_bit = 1'b0;
        case (size)
            SZ_BYTE: begin
                be      = BE_W'(1) << ofs;
                wr_lane = {BE_W{wr_data[7:0]}};
                ext_bit = op_is_signed(op) & byte_sel[7];
                rd_ext  = {{(WORD_DATA_WIDTH-8){ext_bit}}, byte_sel};
            end
            SZ_HALF: begin
                be      = BE_W'(3) << ofs;
                wr_lane = {(BE_W/2){wr_data[15:0]}};
                ext_bit = op_is_signed(op) & half_sel[15];
                rd_ext  = {{(WORD_DATA_WIDTH-16){ext_bit}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-stage bus controller: runs one bus access per aligned load/store,
// with timeout, flush handling and the aligned/extended result back to the pipeline.
module mem_bus_ctrl
    import cpu_pkg::*;
#(
    parameter int WORD_DATA_WIDTH = 32,
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int TIMEOUT_CYC     = 15,
    localparam int BE_W  = WORD_DATA_WIDTH / 8,
    localparam int OFS_W = $clog2(BE_W)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             exe_en_i,
    input  logic [3:0]                       exe_mem_op_i,
    input  logic [WORD_DATA_WIDTH-1:0]       exe_mem_wr_data_i,
    input  logic [WORD_ADDR_WIDTH+OFS_W-1:0] exe_out_i,
    input  logic                             flush_i,
    input  logic [WORD_DATA_WIDTH-1:0]       bus_rd_data_i,
    input  logic                             bus_rdy_i,
    output logic [WORD_ADDR_WIDTH-1:0]       bus_addr_o,
    output logic                             bus_as_o,
    output logic                             bus_rw_o,
    output logic [BE_W-1:0]                  bus_be_o,
    output logic [WORD_DATA_WIDTH-1:0]       bus_wr_data_o,
    output logic [WORD_DATA_WIDTH-1:0]       out_o,
    output logic                             busy_o,
    output logic                             miss_align_o,
    output logic                             bus_err_o
);

    localparam int            CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mem_state_e                 state;
    logic [3:0]                 op_q;
    logic [OFS_W-1:0]           ofs_q;
    logic                       rw_q;
    logic [BE_W-1:0]            be_q;
    logic [CNT_W-1:0]           cnt;
    logic [WORD_DATA_WIDTH-1:0] result_q;
    logic                       err_q;
    logic                       flush_q;

    logic [OFS_W-1:0]           ofs;
    mem_size_e                  size;
    logic                       is_mem;
    logic                       misaligned;
    logic                       start;
    logic                       flush_seen;
    logic [3:0]                 lane_op;
    logic [OFS_W-1:0]           lane_ofs;
    logic [BE_W-1:0]            lane_be;
    logic [WORD_DATA_WIDTH-1:0] lane_wr;
    logic [WORD_DATA_WIDTH-1:0] lane_rd;

    assign ofs        = exe_out_i[OFS_W-1:0];
    assign size       = op_size(exe_mem_op_i);
    assign is_mem     = exe_en_i && op_is_mem(exe_mem_op_i);
    assign start      = (state == ST_IDLE) && is_mem && !misaligned && !flush_i;
    assign flush_seen = flush_q | flush_i;

    always_comb begin
        misaligned = 1'b0;
        if (size == SZ_HALF) begin
            misaligned = ofs[0];
        end else if (size == SZ_WORD) begin
            misaligned = |ofs;
        end
    end

    // Lanes follow the incoming op while idle and the captured op during the access.
    assign lane_op  = (state == ST_IDLE) ? exe_mem_op_i : op_q;
    assign lane_ofs = (state == ST_IDLE) ? ofs : ofs_q;

    mem_lane_align #(
        .WORD_DATA_WIDTH(WORD_DATA_WIDTH)
    ) u_lane_align (
        .op      (lane_op),
        .ofs     (lane_ofs),
        .wr_data (exe_mem_wr_data_i),
        .rd_data (bus_rd_data_i),
        .be      (lane_be),
        .wr_lane (lane_wr),
        .rd_ext  (lane_rd)
    );

    always_comb begin
        bus_as_o     = (state == ST_ACCESS);
        bus_rw_o     = 1'b1;
        bus_be_o     = '0;
        if (bus_as_o) begin
            bus_rw_o = rw_q;
            bus_be_o = be_q;
        end
        busy_o       = start || bus_as_o;
        miss_align_o = (state == ST_IDLE) && is_mem && misaligned;
        bus_err_o    = (state == ST_DONE) && err_q;
        out_o        = '0;
        if (state == ST_DONE) begin
            out_o = result_q;
        end else if ((state == ST_IDLE) && exe_en_i && !op_is_mem(exe_mem_op_i)) begin
            out_o = WORD_DATA_WIDTH'(exe_out_i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus_addr_o    <= '0;
            bus_wr_data_o <= '0;
            op_q          <= NOP;
            ofs_q         <= '0;
            rw_q          <= 1'b1;
            be_q          <= '0;
            cnt           <= '0;
            result_q      <= '0;
            err_q         <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus_addr_o    <= exe_out_i[WORD_ADDR_WIDTH+OFS_W-1:OFS_W];
                        bus_wr_data_o <= op_is_store(exe_mem_op_i) ? lane_wr : '0;
                        op_q          <= exe_mem_op_i;
                        ofs_q         <= ofs;
                        rw_q          <= !op_is_store(exe_mem_op_i);
                        be_q          <= lane_be;
                        cnt           <= '0;
                        err_q         <= 1'b0;
                        flush_q       <= 1'b0;
                        state         <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (flush_i) begin
                        flush_q <= 1'b1;
                    end
                    // A flushed access still completes on the bus but reports nothing.
                    if (bus_rdy_i) begin
                        result_q <= (flush_seen || !rw_q) ? '0 : lane_rd;
                        err_q    <= 1'b0;
                        state    <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        result_q <= '0;
                        err_q    <= !flush_seen;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed corner cases plus randomized
// loads/stores checked against an arithmetic reference model.
module tb_mem_bus_ctrl;

    localparam int TMO     = 15;
    localparam int OP_NOP  = 0;
    localparam int OP_LDW  = 1;
    localparam int OP_LDH  = 2;
    localparam int OP_LDHU = 3;
    localparam int OP_LDB  = 4;
    localparam int OP_LDBU = 5;
    localparam int OP_STW  = 6;
    localparam int OP_STH  = 7;
    localparam int OP_STB  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_en_i;
    logic [3:0]  exe_mem_op_i;
    logic [31:0] exe_mem_wr_data_i;
    logic [31:0] exe_out_i;
    logic        flush_i;
    logic [31:0] bus_rd_data_i;
    logic        bus_rdy_i;
    logic [29:0] bus_addr_o;
    logic        bus_as_o;
    logic        bus_rw_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wr_data_o;
    logic [31:0] out_o;
    logic        busy_o;
    logic        miss_align_o;
    logic        bus_err_o;

    int vectors     = 0;
    int miscompares = 0;

    mem_bus_ctrl #(
        .WORD_DATA_WIDTH(32),
        .WORD_ADDR_WIDTH(30),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .exe_en_i          (exe_en_i),
        .exe_mem_op_i      (exe_mem_op_i),
        .exe_mem_wr_data_i (exe_mem_wr_data_i),
        .exe_out_i         (exe_out_i),
        .flush_i           (flush_i),
        .bus_rd_data_i     (bus_rd_data_i),
        .bus_rdy_i         (bus_rdy_i),
        .bus_addr_o        (bus_addr_o),
        .bus_as_o          (bus_as_o),
        .bus_rw_o          (bus_rw_o),
        .bus_be_o          (bus_be_o),
        .bus_wr_data_o     (bus_wr_data_o),
        .out_o             (out_o),
        .busy_o            (busy_o),
        .miss_align_o      (miss_align_o),
        .bus_err_o         (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, enables, replicated store data, extended load.
    function automatic int op_bytes(input int op);
        if (op == OP_LDW || op == OP_STW) return 4;
        if (op == OP_LDH || op == OP_LDHU || op == OP_STH) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] ref_be(input int op, input logic [31:0] addr);
        int n = op_bytes(op);
        if (n == 4) return 32'hF;
        return 32'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input int op, input logic [31:0] d);
        int n = op_bytes(op);
        if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input int op, input logic [31:0] addr, input logic [31:0] rd);
        int n = op_bytes(op);
        logic [31:0] mask;
        logic [31:0] v;
        if (n == 4) return rd;
        mask = (n == 1) ? 32'hFF : 32'hFFFF;
        v = (rd >> (8 * (addr % 4))) & mask;
        if ((op == OP_LDB || op == OP_LDH) && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "/as"},    32'(bus_as_o), 32'd0);
        check({tag, "/rw"},    32'(bus_rw_o), 32'd1);
        check({tag, "/be"},    32'(bus_be_o), 32'd0);
        check({tag, "/addr"},  32'(bus_addr_o), 32'd0);
        check({tag, "/wdata"}, bus_wr_data_o, 32'd0);
        check({tag, "/out"},   out_o, 32'd0);
        check({tag, "/busy"},  32'(busy_o), 32'd0);
        check({tag, "/err"},   32'(bus_err_o), 32'd0);
        check({tag, "/miss"},  32'(miss_align_o), 32'd0);
    endtask

    // One pipeline memory op; waits = ACCESS cycles before rdy, flush_at = ACCESS cycle index of a flush pulse.
    task automatic run_mem(input string tag, input int op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int waits, input int flush_at);
        int          n       = op_bytes(op);
        bit          store   = (op >= OP_STW);
        bit          aligned = ((addr % n) == 0);
        int          n_acc   = (waits < TMO) ? waits + 1 : TMO;
        bit          flushed = (flush_at >= 0) && (flush_at < n_acc);
        bit          exp_err = (waits >= TMO) && !flushed;
        logic [31:0] exp_out;
        exp_out = (flushed || store || waits >= TMO) ? 32'd0 : ref_load(op, addr, rd);

        @(posedge clk); #1;
        exe_en_i = 1'b1; exe_mem_op_i = 4'(op); exe_out_i = addr;
        exe_mem_wr_data_i = wd; flush_i = 1'b0; bus_rdy_i = 1'b0;
        #4;
        check({tag, "/miss"},  32'(miss_align_o), 32'(!aligned));
        check({tag, "/busy0"}, 32'(busy_o), 32'(aligned));
        check({tag, "/as0"},   32'(bus_as_o), 32'd0);
        if (!aligned) begin
            check({tag, "/mout"}, out_o, 32'd0);
            @(posedge clk); #1;
            exe_en_i = 1'b0;
            #4;
            check({tag, "/mas"}, 32'(bus_as_o), 32'd0);
            return;
        end

        for (int k = 0; k < n_acc; k++) begin
            @(posedge clk); #1;
            bus_rdy_i     = (k == waits);
            flush_i       = (k == flush_at);
            bus_rd_data_i = bus_rdy_i ? rd : $urandom();
            #4;
            check({tag, "/as"},   32'(bus_as_o), 32'd1);
            check({tag, "/busy"}, 32'(busy_o), 32'd1);
            check({tag, "/rw"},   32'(bus_rw_o), 32'(!store));
            check({tag, "/be"},   32'(bus_be_o), ref_be(op, addr));
            check({tag, "/addr"}, 32'(bus_addr_o), addr >> 2);
            if (store) check({tag, "/wdata"}, bus_wr_data_o, ref_wdata(op, wd));
        end

        @(posedge clk); #1;
        bus_rdy_i = 1'b0; flush_i = 1'b0; bus_rd_data_i = $urandom();
        #4;
        check({tag, "/done_as"},   32'(bus_as_o), 32'd0);
        check({tag, "/done_busy"}, 32'(busy_o), 32'd0);
        check({tag, "/done_be"},   32'(bus_be_o), 32'd0);
        check({tag, "/done_rw"},   32'(bus_rw_o), 32'd1);
        check({tag, "/out"},       out_o, exp_out);
        check({tag, "/err"},       32'(bus_err_o), 32'(exp_err));

        @(posedge clk); #1;
        exe_en_i = 1'b0;
        #4;
        check({tag, "/idle_as"},  32'(bus_as_o), 32'd0);
        check({tag, "/idle_err"}, 32'(bus_err_o), 32'd0);
        check({tag, "/idle_out"}, out_o, 32'd0);
    endtask

    int          r_op;
    int          r_waits;
    int          r_flush;
    logic [31:0] r_addr;

    initial begin
        reset = 1'b1; exe_en_i = 1'b0; exe_mem_op_i = '0; exe_mem_wr_data_i = '0;
        exe_out_i = '0; flush_i = 1'b0; bus_rd_data_i = '0; bus_rdy_i = 1'b0;
        #3;
        check_reset_state("por");
        @(posedge clk); #1;
        reset = 1'b0;

        // Non-memory ops pass the ALU result straight through.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            exe_en_i     = 1'b1;
            exe_mem_op_i = (i == 0) ? 4'(OP_NOP) : 4'(9 + $urandom_range(0, 6));
            exe_out_i    = $urandom();
            #4;
            check("pass/out",  out_o, exe_out_i);
            check("pass/busy", 32'(busy_o), 32'd0);
            check("pass/as",   32'(bus_as_o), 32'd0);
            check("pass/miss", 32'(miss_align_o), 32'd0);
        end
        @(posedge clk); #1;
        exe_en_i = 1'b0;

        run_mem("ldb103",  OP_LDB, 32'h103, 32'h0, 32'h80FF_FF12, 0, -1);
        run_mem("sth202",  OP_STH, 32'h202, 32'h0000_ABCD, 32'h0, 0, -1);
        run_mem("ldw101",  OP_LDW, 32'h101, 32'h0, 32'h0, 0, -1);
        run_mem("timeout", OP_LDW, 32'h400, 32'h0, 32'h0, 99, -1);
        run_mem("rdy_last", OP_LDW, 32'h408, 32'h0, 32'hCAFE_F00D, TMO - 1, -1);
        run_mem("flush",   OP_LDW, 32'h404, 32'h0, 32'h1234_5678, 2, 1);
        run_mem("flushto", OP_LDH, 32'h40A, 32'h0, 32'h0, 99, 3);
        run_mem("ldhu",    OP_LDHU, 32'h40A, 32'h0, 32'h8001_7FFF, 1, -1);
        run_mem("stb",     OP_STB, 32'h501, 32'h1234_56A5, 32'h0, 3, -1);

        // A flush while idle cancels the start.
        @(posedge clk); #1;
        exe_en_i = 1'b1; exe_mem_op_i = 4'(OP_LDW); exe_out_i = 32'h10; flush_i = 1'b1;
        #4;
        check("iflush/busy", 32'(busy_o), 32'd0);
        check("iflush/miss", 32'(miss_align_o), 32'd0);
        @(posedge clk); #1;
        exe_en_i = 1'b0; flush_i = 1'b0;
        #4;
        check("iflush/as", 32'(bus_as_o), 32'd0);

        // Reset in the middle of an access clears everything without a clock edge.
        @(posedge clk); #1;
        exe_en_i = 1'b1; exe_mem_op_i = 4'(OP_STW); exe_out_i = 32'h800;
        exe_mem_wr_data_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        #1;
        check("rst/pre_as", 32'(bus_as_o), 32'd1);
        #1;
        reset = 1'b1; exe_en_i = 1'b0;
        #1;
        check_reset_state("rst_access");
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        #4;
        check("rst/after_as",  32'(bus_as_o), 32'd0);
        check("rst/after_err", 32'(bus_err_o), 32'd0);
        check("rst/after_out", out_o, 32'd0);

        for (int i = 0; i < 60; i++) begin
            r_op   = $urandom_range(OP_LDW, OP_STB);
            r_addr = $urandom_range(0, 32'hFFFF);
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~32'(op_bytes(r_op) - 1);
            r_waits = ($urandom_range(0, 9) == 0) ? 16 + $urandom_range(0, 3) : $urandom_range(0, 4);
            r_flush = ($urandom_range(0, 5) == 0) ? $urandom_range(0, (r_waits < TMO) ? r_waits : TMO - 1) : -1;
            run_mem("rand", r_op, r_addr, $urandom(), $urandom(), r_waits, r_flush);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
